// File: rtl/fp_dp4_feeder.sv
// Packs up to four (x,y) pairs into the dp4 operand lanes, holds them for one EVAL cycle, then registers z/status.
// Result is valid 1 cycle after the closing beat; in_ready stays low until the held result is taken by out_ready.
module fp_dp4_feeder #(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic                           inst_clk,
    input  logic                           inst_rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sig_width+exp_width:0]   in_x,
    input  logic [sig_width+exp_width:0]   in_y,
    input  logic                           in_last,
    input  logic [2:0]                     inst_rnd,
    output logic [sig_width+exp_width:0]   dp_a,
    output logic [sig_width+exp_width:0]   dp_b,
    output logic [sig_width+exp_width:0]   dp_c,
    output logic [sig_width+exp_width:0]   dp_d,
    output logic [sig_width+exp_width:0]   dp_e,
    output logic [sig_width+exp_width:0]   dp_f,
    output logic [sig_width+exp_width:0]   dp_g,
    output logic [sig_width+exp_width:0]   dp_h,
    output logic [2:0]                     dp_rnd,
    input  logic [sig_width+exp_width:0]   dp_z,
    input  logic [7:0]                     dp_status,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sig_width+exp_width:0]   out_z,
    output logic [7:0]                     out_status
);
    localparam int W = sig_width + exp_width + 1;

    typedef enum logic [1:0] {FILL = 2'd0, EVAL = 2'd1, OUT = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [W-1:0]   lane_q [8];
    logic [W-1:0]   lane_d [8];
    logic [2:0]     rnd_q, rnd_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   z_q, z_d;
    logic [7:0]     st_q, st_d;
    logic           accept;
    logic           close;

    assign accept = in_valid & in_ready;
    // Beat 3 closes the vector even without in_last: only four lane pairs exist.
    assign close  = accept & (in_last | (cnt_q == 2'd3));

    always_ff @(posedge inst_clk) begin
        if (inst_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close) state_d = EVAL;
            EVAL:    state_d = OUT;
            OUT:     if (vld_q & out_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == FILL) & ~inst_rst;
        out_valid = vld_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        lane_d = lane_q;
        rnd_d  = rnd_q;
        vld_d  = vld_q;
        z_d    = z_q;
        st_d   = st_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    lane_d[{cnt_q, 1'b0}] = in_x;
                    lane_d[{cnt_q, 1'b1}] = in_y;
                    if (cnt_q == 2'd0) rnd_d = inst_rnd;
                    cnt_d = close ? 2'd0 : cnt_q + 2'd1;
                end
            end
            EVAL: begin
                z_d   = dp_z;
                st_d  = dp_status;
                vld_d = 1'b1;
            end
            OUT: begin
                // Clearing lanes here makes the next short vector zero-padded for free.
                if (vld_q & out_ready) begin
                    vld_d  = 1'b0;
                    lane_d = '{default: '0};
                    rnd_d  = 3'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge inst_clk) begin
        if (inst_rst) begin
            cnt_q  <= 2'd0;
            lane_q <= '{default: '0};
            rnd_q  <= 3'd0;
            vld_q  <= 1'b0;
            z_q    <= '0;
            st_q   <= 8'd0;
        end else begin
            cnt_q  <= cnt_d;
            lane_q <= lane_d;
            rnd_q  <= rnd_d;
            vld_q  <= vld_d;
            z_q    <= z_d;
            st_q   <= st_d;
        end
    end

    assign dp_a       = lane_q[0];
    assign dp_b       = lane_q[1];
    assign dp_c       = lane_q[2];
    assign dp_d       = lane_q[3];
    assign dp_e       = lane_q[4];
    assign dp_f       = lane_q[5];
    assign dp_g       = lane_q[6];
    assign dp_h       = lane_q[7];
    assign dp_rnd     = rnd_q;
    assign out_z      = z_q;
    assign out_status = st_q;
endmodule

// File: doc/fp_dp4_feeder.md
# fp_dp4_feeder

Operand-gathering front end for the 4-term floating-point dot-product unit (DW_fp_dp4). Accepts a stream of (x, y) element pairs over a valid/ready handshake, packs up to four pairs into the eight dot-product operand lanes (zero-padding short vectors), and holds them stable for one evaluation cycle. It then captures the unit's z/status into an output register and presents the result on a valid/ready handshake. The dot-product unit itself stays combinational and is instantiated alongside this block by the parent.

## Interface
- sig_width, 23, significand width of operands and result
- exp_width, 8, exponent width; word width W = sig_width+exp_width+1

- inst_clk  in  1  clock, all state on rising edge
- inst_rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  feeder accepts a pair this cycle
- in_x  in  W  first factor of the pair
- in_y  in  W  second factor of the pair
- in_last  in  1  pair is the final element of the vector
- inst_rnd  in  3  rounding mode, sampled on beat 0 of each vector
- dp_a … dp_h  out  W each  operand lanes to dot-product unit
- dp_rnd  out  3  latched rounding mode to dot-product unit
- dp_z  in  W  dot-product result
- dp_status  in  8  dot-product status flags
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_z  out  W  registered result
- out_status  out  8  registered status

## Operation
- States: FILL, EVAL, OUT. Reset state FILL.
- Reset (inst_rst high at an edge): state←FILL, beat count←0, all lanes and dp_rnd←0, out_valid←0, out_z←0, out_status←0. in_ready is 0 while inst_rst is high.
- FILL: in_ready=1. A beat is accepted on in_valid&in_ready. Beat k (0..3) writes in_x/in_y to lanes (a,b), (c,d), (e,f), (g,h) respectively. Beat 0 also latches inst_rnd into dp_rnd; inst_rnd is ignored on beats 1–3.
- Vector closes on an accepted beat with in_last=1, or on accepted beat 3 regardless of in_last. On close: count←0, state←EVAL. Otherwise count increments.
- Unwritten lanes keep their cleared value 0 (+0.0), so a short vector contributes 0 from the padded terms.
- EVAL: in_ready=0. Lanes and dp_rnd are stable for the whole cycle. At the closing edge, out_z←dp_z, out_status←dp_status, out_valid←1, state←OUT.
- OUT: in_ready=0, out_valid=1, out_z/out_status held. On out_valid&out_ready: out_valid←0, all lanes and dp_rnd←0, state←FILL.
- in_valid is ignored while in_ready=0. There is no accept in EVAL or OUT.
- Reset in any state aborts the partial vector or the pending result. No output handshake completes on a reset edge.

## Timing
- A closing beat accepted at edge k puts the block in EVAL during cycle k→k+1.
- out_valid is high after edge k+1. Latency is 1 cycle from the last beat to the result.
- With out_ready held high, the output handshake completes at edge k+2 and in_ready is 1 after k+2.
- Steady-state throughput is one vector per (beats+2) cycles, so a full 4-beat vector takes 6 cycles.
- dp_* outputs are registered. The dot-product path dp_*→dp_z must close within one clock period.
- out_z and out_status are stable for as long as out_valid is high and out_ready is low.

## Test plan
- Full vector: feed pairs (3F800000,3F800000), (40000000,40000000), (40400000,40400000), (40800000,40800000) with in_last on beat 3 and inst_rnd=0. Required: out_z=41F00000 (30.0), out_status=00, out_valid high 1 cycle after the last beat.
- Short vector: feed (40000000,40400000), then (3F800000,3F800000) with in_last=1. Required: dp_e..dp_h=0 during EVAL, out_z=40E00000 (7.0).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid high. Required: in_ready=0, out_z/out_status unchanged, no beat accepted, next vector accepted only after the handshake.
- Rounding latch: inst_rnd=1 on beat 0, then change it to 3 on beats 1–3. Required: dp_rnd=1 throughout FILL and EVAL of that vector, and dp_rnd=0 after the output handshake.
- Reset mid-fill: accept 2 beats, then assert inst_rst for 1 cycle. Required: lanes=0, out_valid=0, in_ready=0 during reset and 1 after it. The next full vector from the first test yields 41F00000.
- Back-to-back: three full vectors with out_ready=1 and in_valid=1 continuously. Required: out_valid pulses for one cycle every 6 cycles with correct results.
